// File: rtl/l1_mem_arb_pkg.sv
// Shared types and constants for the L1 memory-port arbiter.
package l1_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int DEFAULT_LINE_WORDS = 4;

  // Width of the word-within-line counter.
  function automatic int word_off_w(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/l1_mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: picks I or D, favouring the one not served last.
module rr_pick2
  import l1_mem_arb_pkg::*;
(
  input  logic valid_i,
  input  logic valid_d,
  input  logic last_owner,
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = valid_i | valid_d;
    if (valid_i && valid_d) begin
      owner = ~last_owner;
    end else if (valid_d) begin
      owner = OWNER_D;
    end else begin
      owner = OWNER_I;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one word-wide memory port between I-cache and D-cache line transfers.
// Optional performance counters are built when L1_MEM_ARB_PERF_EN is defined.
module l1_mem_arbiter
  import l1_mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [ADDR_W-1:0]       i_addr,
  output logic                    i_done,
  input  logic                    d_valid,
  input  logic                    d_we,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [32*LINE_WORDS-1:0] d_wdata,
  output logic                    d_done,
  output logic [32*LINE_WORDS-1:0] line_rdata,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy,
`ifdef L1_MEM_ARB_PERF_EN
  output logic [31:0]             perf_i_grants,
  output logic [31:0]             perf_d_grants,
  output logic [31:0]             perf_conflicts,
`endif
  output logic                    owner
);

  localparam int CNT_W = word_off_w(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4 * LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  state_t                   state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [CNT_W-1:0]         cnt_next;
  logic                     last_owner_reg;
  logic [32*LINE_WORDS-1:0] wline_reg;
  logic [31:0]              wword [LINE_WORDS];

  logic                     pick_grant;
  logic                     pick_owner;
  logic                     grant_we;
  logic [ADDR_W-1:0]        grant_addr;

  rr_pick2 u_pick (
    .valid_i    (i_valid),
    .valid_d    (d_valid),
    .last_owner (last_owner_reg),
    .grant      (pick_grant),
    .owner      (pick_owner)
  );

  assign grant_addr = ((pick_owner == OWNER_D) ? d_addr : i_addr) & LINE_MASK;
  assign grant_we   = (pick_owner == OWNER_D) & d_we;
  assign cnt_next   = cnt_reg + CNT_W'(1);

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_wword
    assign wword[gi] = wline_reg[32*gi +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_owner_reg <= OWNER_I;
      wline_reg      <= '0;
      line_rdata     <= '0;
      owner          <= OWNER_I;
      busy           <= 1'b0;
      i_done         <= 1'b0;
      d_done         <= 1'b0;
      mem_cs         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_grant) begin
            state_reg <= BURST;
            cnt_reg   <= '0;
            owner     <= pick_owner;
            busy      <= 1'b1;
            mem_cs    <= 1'b1;
            mem_we    <= grant_we;
            mem_addr  <= grant_addr;
            // The write line is captured once so later d_wdata changes cannot leak in.
            wline_reg <= (pick_owner == OWNER_D) ? d_wdata : '0;
            mem_wdata <= (pick_owner == OWNER_D) ? d_wdata[31:0] : '0;
          end
        end
        BURST: begin
          if (mem_ack) begin
            if (!mem_we) begin
              line_rdata[32*int'(cnt_reg) +: 32] <= mem_rdata;
            end
            if (cnt_reg == CNT_LAST) begin
              state_reg <= DONE;
              mem_cs    <= 1'b0;
              mem_we    <= 1'b0;
              i_done    <= (owner == OWNER_I);
              d_done    <= (owner == OWNER_D);
            end else begin
              cnt_reg   <= cnt_next;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_wdata <= wword[cnt_next];
            end
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          busy           <= 1'b0;
          last_owner_reg <= owner;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef L1_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state_reg == IDLE) begin
      if (i_valid && d_valid) begin
        perf_conflicts <= perf_conflicts + 32'd1;
      end
      if (pick_grant && (pick_owner == OWNER_I)) begin
        perf_i_grants <= perf_i_grants + 32'd1;
      end
      if (pick_grant && (pick_owner == OWNER_D)) begin
        perf_d_grants <= perf_d_grants + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized bench for l1_mem_arbiter against a transaction-level model.
module tb_l1_mem_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;
  localparam logic [31:0] AMASK = ~32'(LW * 4 - 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic [31:0]       i_addr = '0;
  logic              i_done;
  logic              d_valid = 1'b0;
  logic              d_we = 1'b0;
  logic [31:0]       d_addr = '0;
  logic [32*LW-1:0]  d_wdata = '0;
  logic              d_done;
  logic [32*LW-1:0]  line_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              busy;
  logic              owner;
`ifdef L1_MEM_ARB_PERF_EN
  logic [31:0]       perf_i_grants;
  logic [31:0]       perf_d_grants;
  logic [31:0]       perf_conflicts;
`endif

  always #5 clk = ~clk;

  l1_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_addr     (i_addr),
    .i_done     (i_done),
    .d_valid    (d_valid),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .line_rdata (line_rdata),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
`ifdef L1_MEM_ARB_PERF_EN
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts),
`endif
    .owner      (owner)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Transaction-level model: one line transfer at a time, counted in acks.
  bit               m_active = 0;
  bit               m_done = 0;
  bit               m_owner = 0;
  bit               m_last = 0;
  bit               m_we = 0;
  int               m_acks = 0;
  logic [31:0]      m_base = '0;
  logic [32*LW-1:0] m_wline = '0;
  logic [31:0]      m_ig = 0;
  logic [31:0]      m_dg = 0;
  logic [31:0]      m_conf = 0;

  // Stimulus controls.
  bit en_i = 0, en_d = 0, hold = 0, toggle_i = 0, drop_d = 0, spur = 0;
  bit i_out = 0, d_out = 0;
  int d_mode = 0;
  int lat_fixed = 1;
  int wt = -1;
  int done_seq[$];

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [32*LW-1:0] got, input logic [32*LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit               pi, pd, pa, prst, pdwe;
    logic [31:0]      pia, pda;
    logic [32*LW-1:0] pdw;
    logic [32*LW-1:0] el;
    pi = i_valid; pd = d_valid; pa = mem_ack; prst = rst;
    pia = i_addr; pda = d_addr; pdwe = d_we; pdw = d_wdata;
    @(posedge clk);
    #1;
    cyc++;

    if (prst) begin
      m_active = 0; m_done = 0; m_owner = 0; m_last = 0; m_acks = 0;
      m_ig = 0; m_dg = 0; m_conf = 0;
      mem_ack = 1'b0; wt = -1;
    end else if (m_done) begin
      m_done = 0;
      m_last = m_owner;
    end else if (m_active) begin
      if (pa) begin
        m_acks++;
        if (m_acks == LW) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end else if (pi || pd) begin
      if (pi && pd) begin
        m_conf++;
        m_owner = !m_last;
      end else begin
        m_owner = pd;
      end
      if (m_owner) begin
        m_base = pda & AMASK; m_we = pdwe; m_wline = pdw; m_dg++;
      end else begin
        m_base = pia & AMASK; m_we = 0; m_ig++;
      end
      m_active = 1;
      m_acks = 0;
    end

    chk("busy", busy, m_active || m_done);
    chk("mem_cs", mem_cs, m_active);
    chk("i_done", i_done, m_done && !m_owner);
    chk("d_done", d_done, m_done && m_owner);
    chk("owner", owner, m_owner);
    if (m_active) begin
      chk("mem_addr", mem_addr, m_base + 32'(4 * m_acks));
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wline[32*m_acks +: 32]);
    end
    if (m_done && !m_we) begin
      for (int k = 0; k < LW; k++) el[32*k +: 32] = mrd(m_base + 32'(4 * k));
      chk("line", line_rdata, el);
    end
`ifdef L1_MEM_ARB_PERF_EN
    chk("perf_i", perf_i_grants, m_ig);
    chk("perf_d", perf_d_grants, m_dg);
    chk("perf_conf", perf_conflicts, m_conf);
`endif
    if (i_done) done_seq.push_back(0);
    if (d_done) done_seq.push_back(1);

    // Memory responder: ack after 'lat' cycles, one request at a time.
    if (mem_ack) begin
      mem_ack = 1'b0;
      wt = -1;
    end
    if (mem_cs) begin
      if (wt < 0) begin
        wt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
      end else begin
        wt--;
        if (wt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mrd(mem_addr);
          if (mem_we) mem[mem_addr] = mem_wdata;
        end
      end
    end

    // Requesters.
    if (i_done) begin i_valid = 1'b0; i_out = 0; end
    if (d_done) begin d_valid = 1'b0; d_out = 0; end
    if (en_i && !i_out && !i_done && (hold || $urandom_range(0, 2) == 0)) begin
      i_valid = 1'b1; i_out = 1; i_addr = $urandom_range(0, 32'h0FFF);
    end
    if (en_d && !d_out && !d_done && (hold || $urandom_range(0, 2) == 0)) begin
      d_valid = 1'b1; d_out = 1; d_addr = $urandom_range(0, 32'h0FFF);
      d_we = (d_mode == 2) ? 1'($urandom_range(0, 1)) : (d_mode == 1);
      d_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    if (drop_d && m_active && m_owner && m_acks == 2) d_valid = 1'b0;
    if (toggle_i && !i_out) begin
      i_valid = (m_active && m_owner) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_addr = $urandom;
    end
    if (spur && !m_active && !mem_ack && $urandom_range(0, 3) == 0) begin
      mem_ack = 1'b1;
      mem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0; d_valid = 1'b0; i_out = 0; d_out = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (i_out || d_out || m_active || m_done); k++) step();
    if (i_out || d_out || m_active || m_done) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int req_cyc;
    int lat_seen;
    bit hit;

    // Reset state.
    do_reset();
    chk("rst_line", line_rdata, '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_we", mem_we, 0);

    // I-cache solo read, unaligned address, latency 1.
    lat_fixed = 1;
    i_valid = 1'b1; i_addr = 32'h0000_1004; i_out = 1;
    req_cyc = cyc;
    lat_seen = -1;
    for (int k = 0; k < 100 && lat_seen < 0; k++) begin
      step();
      if (i_done) lat_seen = cyc - req_cyc + 1;
    end
    chk("i_solo_latency", lat_seen, 1 + LW * 2 + 1);
    step();
    step();

    // D writeback; d_wdata is scrambled after grant and must not matter.
    d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_out = 1;
    d_wdata = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA};
    for (int k = 0; k < 3; k++) step();
    d_wdata = {4{32'hDEAD_BEEF}};
    drain();
    chk("wb_w0", mrd(32'h2000), 32'h0000_AAAA);
    chk("wb_w1", mrd(32'h2004), 32'h0000_BBBB);
    chk("wb_w2", mrd(32'h2008), 32'h0000_CCCC);
    chk("wb_w3", mrd(32'h200C), 32'h0000_DDDD);

    // Simultaneous requests held continuously: D, I, D, I.
    do_reset();
    done_seq.delete();
    d_mode = 0; hold = 1; en_i = 1; en_d = 1;
    i_valid = 1'b1; i_addr = 32'h0000_0100; i_out = 1;
    d_valid = 1'b1; d_addr = 32'h0000_0200; d_we = 1'b0; d_out = 1;
    for (int k = 0; k < 300 && done_seq.size() < 4; k++) step();
    en_i = 0; en_d = 0; hold = 0;
    chk("rr_count", done_seq.size() >= 4, 1);
    if (done_seq.size() >= 4) begin
      chk("rr_0", done_seq[0], 1);
      chk("rr_1", done_seq[1], 0);
      chk("rr_2", done_seq[2], 1);
      chk("rr_3", done_seq[3], 0);
    end
    drain();

    // Random traffic with variable memory latency.
    lat_fixed = 0; d_mode = 2; en_i = 1; en_d = 1;
    for (int k = 0; k < 1500; k++) step();
    en_i = 0; en_d = 0;
    drain();

    // Reset in the middle of a D refill, then a clean I read.
    d_mode = 0; en_d = 1;
    hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      step();
      hit = m_active && m_owner && (m_acks == 2) && !m_we;
    end
    chk("mid_reset_reached", hit, 1);
    en_d = 0;
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0; i_out = 0; d_out = 0;
    step();
    rst = 1'b0;
    chk("mid_rst_cs", mem_cs, 0);
    chk("mid_rst_ddone", d_done, 0);
    chk("mid_rst_line", line_rdata, '0);
    step();
    i_valid = 1'b1; i_addr = 32'h0000_3008; i_out = 1;
    drain();

    // Spurious acks, i_valid toggling during D bursts, D dropping valid mid-burst.
    en_d = 1; d_mode = 2; toggle_i = 1; drop_d = 1; spur = 1;
    for (int k = 0; k < 600; k++) step();
    en_d = 0; spur = 0; drop_d = 0;
    drain();
    toggle_i = 0; i_valid = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
